// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline payload: field widths, offsets and keep mask.
// Used by pipe_stage_reg (optional skid entry enabled with PIPE_STAGE_SKID_EN).
package pipe_pkg;

  localparam int INSTR_W   = 32;
  localparam int PC_W      = 32;
  localparam int INSTR_LSB = 0;
  localparam int PC4_LSB   = INSTR_LSB + INSTR_W;
  localparam int PC8_LSB   = PC4_LSB + PC_W;
  localparam int FD_W      = PC8_LSB + PC_W;

  typedef struct packed {
    logic [PC_W-1:0]    pc8;
    logic [PC_W-1:0]    pc4;
    logic [INSTR_W-1:0] instr;
  } fd_payload_t;

  // PCs survive a flush so the bubble still carries a return address; instr clears to a NOP.
  localparam logic [FD_W-1:0] FD_KEEP_MASK = {{(2*PC_W){1'b1}}, {INSTR_W{1'b0}}};

  function automatic logic [FD_W-1:0] fd_pack(input logic [INSTR_W-1:0] instr,
                                              input logic [PC_W-1:0] pc4,
                                              input logic [PC_W-1:0] pc8);
    fd_payload_t p;
    p.pc8   = pc8;
    p.pc4   = pc4;
    p.instr = instr;
    return p;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle between pipeline stages.
// The producer side uses the master modport, the consumer side the slave modport.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 96
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_sat_ctr.sv
// Saturating up-counter with a 0..3 increment per cycle; sticks at all-ones, never wraps.
module pipe_sat_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign sum        = {1'b0, count_reg} + (CNT_W+1)'(inc);
  assign count_next = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  assign count      = count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with flush/intflush, per-bit keep mask and killed-beat counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = FD_W,
  parameter logic [DATA_W-1:0] KEEP_MASK = DATA_W'(FD_KEEP_MASK),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stage_reg_if.slave   in_bus,
  pipe_stage_reg_if.master  out_bus,
  input  logic              flush,
  input  logic              intflush,
  output logic [CNT_W-1:0]  kill_cnt
);

  logic              kill;
  logic              accept;
  logic              deliver;
  logic              main_valid_reg;
  logic              main_valid_next;
  logic [DATA_W-1:0] main_data_reg;
  logic [DATA_W-1:0] main_data_next;
  logic [DATA_W-1:0] kept_data;
  logic [1:0]        kill_inc;

  assign kill    = flush | intflush;
  assign accept  = in_bus.valid & in_bus.ready;
  assign deliver = main_valid_reg & out_bus.ready;

  assign out_bus.valid = main_valid_reg;
  assign out_bus.data  = main_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_keep
      assign kept_data[gi] = KEEP_MASK[gi] ? main_data_reg[gi] : 1'b0;
    end
  endgenerate

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_reg;
  logic              skid_valid_next;
  logic [DATA_W-1:0] skid_data_reg;
  logic [DATA_W-1:0] skid_data_next;
  logic              in_ready_reg;

  assign in_bus.ready = in_ready_reg;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    kill_inc        = 2'd0;
    if (kill) begin
      // A beat delivered on the kill edge was consumed, so only the leftovers count.
      main_valid_next = 1'b0;
      main_data_next  = kept_data;
      skid_valid_next = 1'b0;
      kill_inc        = {1'b0, main_valid_reg & ~deliver} + {1'b0, skid_valid_reg};
    end else if (!main_valid_reg || deliver) begin
      if (skid_valid_reg) begin
        main_valid_next = 1'b1;
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end else begin
        main_valid_next = accept;
        if (accept) begin
          main_data_next = in_bus.data;
        end
      end
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_bus.data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      in_ready_reg   <= 1'b1;
    end else begin
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      in_ready_reg   <= ~skid_valid_next;
    end
  end
`else
  assign in_bus.ready = ~main_valid_reg | out_bus.ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    kill_inc        = 2'd0;
    if (kill) begin
      main_valid_next = 1'b0;
      main_data_next  = kept_data;
      kill_inc        = {1'b0, main_valid_reg & ~deliver};
    end else if (!main_valid_reg || deliver) begin
      main_valid_next = accept;
      if (accept) begin
        main_data_next = in_bus.data;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
    end
  end

  pipe_sat_ctr #(
    .CNT_W (CNT_W)
  ) u_kill_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (kill_inc),
    .count (kill_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; adapts its in_ready expectations to PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 96;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [DW-1:0] KEEP = {{64{1'b1}}, 32'h0};

  logic        clk;
  logic        reset;
  logic        flush;
  logic        intflush;
  logic [15:0] kill_cnt;
  logic        s_flush;
  logic [1:0]  s_kill_cnt;

  pipe_stage_reg_if #(.DATA_W(DW)) up_if ();
  pipe_stage_reg_if #(.DATA_W(DW)) dn_if ();
  pipe_stage_reg_if #(.DATA_W(DW)) s_up_if ();
  pipe_stage_reg_if #(.DATA_W(DW)) s_dn_if ();

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_bus   (up_if),
    .out_bus  (dn_if),
    .flush    (flush),
    .intflush (intflush),
    .kill_cnt (kill_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(2)) dut_sat (
    .clk      (clk),
    .reset    (reset),
    .in_bus   (s_up_if),
    .out_bus  (s_dn_if),
    .flush    (s_flush),
    .intflush (1'b0),
    .kill_cnt (s_kill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  logic [DW-1:0] src[$];   // upstream beats waiting to be accepted
  logic [DW-1:0] sb[$];    // scoreboard: accepted, not yet delivered
  logic [DW-1:0] m_data;
  int            m_cnt;
  bit            m_rdy;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    src.delete();
    m_data = '0;
    m_cnt  = 0;
    m_rdy  = 1'b1;
  endtask

  // One clock: drive at posedge+1, check and advance the model at negedge.
  task automatic step(input bit en, input bit o_rdy, input bit fl, input bit ifl);
    bit            exp_rdy;
    bit            acc;
    bit            dlv;
    int            killed;
    logic [DW-1:0] beat;
    logic [DW-1:0] offered;
    offered     = (src.size() > 0) ? src[0] : '0;
    up_if.valid = en && (src.size() > 0);
    up_if.data  = offered;
    dn_if.ready = o_rdy;
    flush       = fl;
    intflush    = ifl;
    @(negedge clk);
    exp_rdy = SKID ? m_rdy : ((sb.size() == 0) || o_rdy);
    check_eq("in_ready", up_if.ready, exp_rdy);
    check_eq("out_valid", dn_if.valid, sb.size() > 0);
    check_eq("out_data", dn_if.data, m_data);
    check_eq("kill_cnt", kill_cnt, m_cnt);
    acc = up_if.valid && exp_rdy;
    dlv = (sb.size() > 0) && o_rdy;
    if (dlv) begin
      beat = sb.pop_front();
      check_eq("deliver", dn_if.data, beat);
      $display("[TB] deliver %h", beat);
    end
    if (acc) void'(src.pop_front());
    if (fl || ifl) begin
      killed = sb.size();
      sb.delete();
      m_cnt  = (m_cnt + killed > 65535) ? 65535 : m_cnt + killed;
      m_data = m_data & KEEP;
      $display("[TB] kill killed=%0d cnt=%0d", killed, m_cnt);
    end else begin
      if (acc) sb.push_back(offered);
      if (sb.size() > 0) m_data = sb[0];
    end
    m_rdy = sb.size() < 2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a_beat;
    int            cnt_before;
    int            sat_exp[5];
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    flush        = 1'b0;
    intflush     = 1'b0;
    s_flush      = 1'b0;
    up_if.valid  = 1'b0;
    up_if.data   = '0;
    dn_if.ready  = 1'b0;
    s_up_if.valid = 1'b0;
    s_up_if.data  = '0;
    s_dn_if.ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 0, 0, 0);

    // Streaming: eight back-to-back beats with no stall.
    for (int i = 1; i <= 8; i++) src.push_back(fd_pack(32'h0 + i, 32'h2000_0000 + i, 32'h3000_0000 + i));
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);

    // Stall: A held, B goes to skid (or waits upstream), then drain in order.
    src.push_back(fd_pack(32'hAAAA_0001, 32'h0000_1004, 32'h0000_1008));
    src.push_back(fd_pack(32'hBBBB_0002, 32'h0000_1008, 32'h0000_100C));
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

    // Full stage plus flush with a beat offered.
    a_beat = fd_pack(32'hDEAD_BEEF, 32'h0000_2004, 32'h0000_2008);
    src.push_back(a_beat);
    src.push_back(fd_pack(32'hCAFE_0001, 32'h0000_2008, 32'h0000_200C));
    src.push_back(fd_pack(32'hCAFE_0002, 32'h0000_200C, 32'h0000_2010));
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    cnt_before = m_cnt;
    step(1, 0, 1, 0);
    check_eq("flush_valid", dn_if.valid, 1'b0);
    check_eq("flush_instr", dn_if.data[31:0], 32'h0);
    check_eq("flush_pc", dn_if.data[95:32], a_beat[95:32]);
    check_eq("flush_cnt", kill_cnt, cnt_before + (SKID ? 2 : 1));
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

    // Kill with an empty stage and a beat accepted: nothing counted.
    src.push_back(fd_pack(32'h1111_0000, 32'h0000_3004, 32'h0000_3008));
    cnt_before = m_cnt;
    step(1, 1, 1, 0);
    check_eq("empty_kill_cnt", kill_cnt, cnt_before);

    // intflush coincident with deliver of the only held beat.
    src.push_back(fd_pack(32'h2222_0000, 32'h0000_4004, 32'h0000_4008));
    step(1, 0, 0, 0);
    cnt_before = m_cnt;
    step(0, 1, 0, 1);
    check_eq("intflush_valid", dn_if.valid, 1'b0);
    check_eq("intflush_cnt", kill_cnt, cnt_before);

    // Random traffic with occasional kills.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) src.push_back({$urandom(), $urandom(), $urandom()});
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 22) == 0, $urandom_range(0, 28) == 0);
    end

    // Reset mid-traffic: asynchronous, nothing survives.
    for (int i = 0; i < 3; i++) src.push_back(fd_pack(32'h5555_0000 + i, 32'h5004, 32'h5008));
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    up_if.valid = 1'b1;
    reset = 1'b0;
    #2;
    check_eq("rst_out_valid", dn_if.valid, 1'b0);
    check_eq("rst_out_data", dn_if.data, '0);
    check_eq("rst_kill_cnt", kill_cnt, 0);
    check_eq("rst_in_ready", up_if.ready, 1'b1);
    model_reset();
    up_if.valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);

    // Two-bit counter saturation: five single-entry kills.
    sat_exp = '{1, 2, 3, 3, 3};
    for (int k = 0; k < 5; k++) begin
      s_up_if.valid = 1'b1;
      s_up_if.data  = fd_pack(32'h7000_0000 + k, 32'h7004, 32'h7008);
      s_dn_if.ready = 1'b0;
      @(posedge clk);
      #1;
      s_up_if.valid = 1'b0;
      s_flush       = 1'b1;
      @(posedge clk);
      #1;
      s_flush = 1'b0;
      check_eq("sat_cnt", s_kill_cnt, sat_exp[k]);
      $display("[TB] sat kill %0d cnt=%0d", k, s_kill_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
